// File: rtl/hex_nibble_display.sv
// hex_nibble_display
//
// Shows a captured byte on a single 7-segment digit as two hex characters in
// turn: high nibble, then low nibble with the decimal point lit, then a blank
// gap. The sequence repeats until a new byte is loaded or reset is asserted.
//
// Parameters:
//   MAX_COUNT  - dwell length of each display phase in clk cycles (1 .. 2^24-1)
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-high reset
//   ena        in   1  enable; low freezes all state and blanks the display
//   data_in    in   8  byte to display, captured on data_valid
//   data_valid in   1  single-cycle load strobe for data_in
//   seg_out    out  8  segment drive, active-high; bit0 = a .. bit6 = g, bit7 = dp
//   busy       out  1  high whenever the block is not idle
module hex_nibble_display #(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic [7:0] seg_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_HI = 2'd1,
    SHOW_LO = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [23:0] LAST_CNT = MAX_COUNT - 24'd1;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] cnt;
  logic [23:0] cnt_nxt;
  logic [7:0]  data_reg;
  logic [7:0]  data_nxt;
  logic [7:0]  seg_raw;

  // Hex digit to segment pattern (a = bit0 .. g = bit6), dp left clear.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h07;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      data_reg <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      data_reg <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_reg;
    if (ena) begin
      if (data_valid) begin
        // A load restarts the sequence from any state, overriding any
        // phase expiry on the same edge.
        data_nxt  = data_in;
        state_nxt = SHOW_HI;
        cnt_nxt   = '0;
      end else if (state != IDLE) begin
        if (cnt == LAST_CNT) begin
          cnt_nxt = '0;
          case (state)
            SHOW_HI: state_nxt = SHOW_LO;
            SHOW_LO: state_nxt = GAP;
            default: state_nxt = SHOW_HI;
          endcase
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
    end
  end

  // Display decode depends only on registered state, never on data_in.
  always_comb begin
    seg_raw = 8'h00;
    case (state)
      SHOW_HI: seg_raw = hex_seg(data_reg[7:4]);
      SHOW_LO: seg_raw = hex_seg(data_reg[3:0]) | 8'h80;
      default: seg_raw = 8'h00;
    endcase
  end

  assign seg_out = ena ? seg_raw : 8'h00;
  assign busy    = (state != IDLE);

endmodule
